// File: rtl/mem_access_unit.sv
// Load/store unit between the datapath and a word-only data memory.
// Ports: clk, rst (sync, active-high); request side req/wr/size/sext/addr/wdata;
// status busy/done/err/rdata; memory side mem_we/mem_a/mem_wd/mem_rd.
module mem_access_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t        state;
    logic          wr_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic [1:0]    lane_q;
    logic [DW-1:0] wdata_q;

    logic          bad;
    logic [3:0]    be;
    logic [DW-1:0] wide;
    logic [DW-1:0] merged;
    logic [DW-1:0] loaded;
    logic [7:0]    lb;
    logic [15:0]   lh;

    // Alignment / size check on the live request.
    always_comb begin
        bad = 1'b0;
        unique case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    // Store data replicated across lanes; byte enables pick which lanes land.
    always_comb begin
        be   = 4'b1111;
        wide = wdata_q;
        unique case (size_q)
            2'b00: begin
                be   = 4'b0001 << lane_q;
                wide = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be   = lane_q[1] ? 4'b1100 : 4'b0011;
                wide = {2{wdata_q[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wide = wdata_q;
            end
        endcase
        merged = mem_rd;
        for (int i = 0; i < 4; i++) begin
            if (be[i])
                merged[8*i +: 8] = wide[8*i +: 8];
        end
    end

    // Sub-word load extraction with optional sign extension.
    always_comb begin
        lb     = mem_rd[{lane_q, 3'b000} +: 8];
        lh     = mem_rd[{lane_q[1], 4'b0000} +: 16];
        loaded = mem_rd;
        unique case (size_q)
            2'b00:   loaded = {{24{sext_q & lb[7]}}, lb};
            2'b01:   loaded = {{16{sext_q & lh[15]}}, lh};
            default: loaded = mem_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            mem_we  <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        wr_q    <= wr;
                        size_q  <= size;
                        sext_q  <= sext;
                        lane_q  <= addr[1:0];
                        wdata_q <= wdata;
                        mem_a   <= {addr[AW-1:2], 2'b00};
                        mem_wd  <= wdata;
                        busy    <= 1'b1;
                        if (bad) begin
                            state <= RSP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (wr && size == 2'b10) begin
                            // Full-word store skips the read phase.
                            state  <= WR;
                            mem_we <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (wr_q) begin
                        mem_wd <= merged;
                        mem_we <= 1'b1;
                        state  <= WR;
                    end else begin
                        rdata <= loaded;
                        done  <= 1'b1;
                        state <= RSP;
                    end
                end
                WR: begin
                    done  <= 1'b1;
                    state <= RSP;
                end
                RSP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small word memory model.
// Ports: drives all request inputs, models memory on mem_we/mem_a/mem_wd/mem_rd.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int we0;
    int dn0;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .sext   (sext),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (mem_we)
            mem[mem_a[7:2]] <= mem_wd;
        if (mem_we)
            we_cnt <= we_cnt + 1;
        if (done)
            done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic se,
                         input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        wr    = w;
        size  = s;
        sext  = se;
        addr  = a;
        wdata = d;
        tick();
        req = 1'b0;
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        wr = 1'b0;
        size = 2'b00;
        sext = 1'b0;
        addr = '0;
        wdata = '0;
        pre_we = 1'b0;
        pre_a = '0;
        pre_d = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_a", mem_a, 32'h0);
        chk("rst_wd", mem_wd, 32'h0);
        rst = 1'b0;
        poke(6'd4, 32'h11223344);
        poke(6'd8, 32'h0);

        // Byte store 0xAB to 0x12
        we0 = we_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
        chk("sb_c1_busy", 32'(busy), 32'd1);
        chk("sb_c1_we", 32'(mem_we), 32'd0);
        tick();
        chk("sb_c2_we", 32'(mem_we), 32'd1);
        chk("sb_c2_a", mem_a, 32'h10);
        chk("sb_c2_wd", mem_wd, 32'h11AB3344);
        tick();
        chk("sb_c3_done", 32'(done), 32'd1);
        chk("sb_c3_err", 32'(err), 32'd0);
        chk("sb_c3_we", 32'(mem_we), 32'd0);
        tick();
        chk("sb_busy_end", 32'(busy), 32'd0);
        chk("sb_mem", mem[4], 32'h11AB3344);
        chk("sb_wecnt", 32'(we_cnt - we0), 32'd1);

        // Byte loads from 0x12
        we0 = we_cnt;
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        chk("lb_c1_done", 32'(done), 32'd0);
        tick();
        chk("lbs_done", 32'(done), 32'd1);
        chk("lbs_rdata", rdata, 32'hFFFFFFAB);
        tick();
        issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        tick();
        chk("lbu_done", 32'(done), 32'd1);
        chk("lbu_rdata", rdata, 32'h000000AB);
        tick();
        chk("lb_wecnt", 32'(we_cnt - we0), 32'd0);

        // Half store / load at 0x12
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
        tick();
        chk("sh_wd", mem_wd, 32'hBEEF3344);
        tick();
        chk("sh_done", 32'(done), 32'd1);
        tick();
        chk("sh_mem", mem[4], 32'hBEEF3344);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        tick();
        chk("lhs_rdata", rdata, 32'hFFFFBEEF);
        tick();

        // Word store / load at 0x20
        we0 = we_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        chk("sw_c1_we", 32'(mem_we), 32'd1);
        chk("sw_c1_a", mem_a, 32'h20);
        chk("sw_c1_wd", mem_wd, 32'hDEADBEEF);
        tick();
        chk("sw_c2_done", 32'(done), 32'd1);
        chk("sw_c2_we", 32'(mem_we), 32'd0);
        tick();
        chk("sw_wecnt", 32'(we_cnt - we0), 32'd1);
        chk("sw_mem", mem[8], 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b1, 32'h20, 32'h0);
        tick();
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        tick();

        // Error cases
        we0 = we_cnt;
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        chk("elh_done", 32'(done), 32'd1);
        chk("elh_err", 32'(err), 32'd1);
        chk("elh_we", 32'(mem_we), 32'd0);
        tick();
        chk("elh_rdata", rdata, 32'hDEADBEEF);
        issue(1'b1, 2'b10, 1'b0, 32'h22, 32'h55555555);
        chk("esw_done", 32'(done), 32'd1);
        chk("esw_err", 32'(err), 32'd1);
        chk("esw_we", 32'(mem_we), 32'd0);
        tick();
        issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        chk("esz_done", 32'(done), 32'd1);
        chk("esz_err", 32'(err), 32'd1);
        tick();
        chk("err_rdata", rdata, 32'hDEADBEEF);
        chk("err_wecnt", 32'(we_cnt - we0), 32'd0);
        chk("err_mem", mem[8], 32'hDEADBEEF);

        // Reset during RD of a byte store
        we0 = we_cnt;
        dn0 = done_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000077);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrd_busy", 32'(busy), 32'd0);
        chk("rrd_we", 32'(mem_we), 32'd0);
        tick();
        tick();
        tick();
        chk("rrd_mem", mem[4], 32'hBEEF3344);
        chk("rrd_wecnt", 32'(we_cnt - we0), 32'd0);
        chk("rrd_donecnt", 32'(done_cnt - dn0), 32'd0);

        // req while busy is ignored
        dn0 = done_cnt;
        we0 = we_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        req  = 1'b1;
        wr   = 1'b1;
        size = 2'b10;
        addr = 32'h10;
        wdata = 32'hCAFEF00D;
        tick();
        chk("rb_rdata", rdata, 32'hDEADBEEF);
        req = 1'b0;
        tick();
        chk("rb_idle", 32'(busy), 32'd0);
        tick();
        tick();
        chk("rb_donecnt", 32'(done_cnt - dn0), 32'd1);
        chk("rb_wecnt", 32'(we_cnt - we0), 32'd0);
        chk("rb_mem", mem[4], 32'hBEEF3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
